fpaddsub_exec_stage: RTL and testbench
======================================

FPADDSUB_EXEC_STAGE -- requirements
Module: fpaddsub_exec_stage

Interface
REQ-001 Parameter: MANTISSA, default 10, mantissa fraction width; the aligned mantissa is MANTISSA+1 bits.
REQ-002 Parameter: EXPONENT, default 5, exponent width.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port: in_valid  input  1  upstream alignment stage presents an operand set.
REQ-006 Port: in_ready  output  1  stage can accept an operand set this cycle.
REQ-007 Port: Mmax  input  MANTISSA+1  larger mantissa, unshifted.
REQ-008 Port: Mmin  input  MANTISSA+1  smaller mantissa, already fully aligned (all shift stages applied).
REQ-009 Port: Opr  input  1  effective operation: 0 = add, 1 = subtract.
REQ-010 Port: Sa  input  1  sign of the larger operand.
REQ-011 Port: Ex  input  EXPONENT  larger exponent.
REQ-012 Port: out_valid  output  1  result is valid.
REQ-013 Port: out_ready  input  1  downstream normaliser accepts the result.
REQ-014 Port: Sum  output  MANTISSA+2  mantissa result including the carry bit.
REQ-015 Port: PSgn  output  1  result sign.
REQ-016 Port: ExOut  output  EXPONENT  exponent passed through with its result.
REQ-017 Port: op_count  output  16  saturating count of accepted operand sets.

Function
REQ-018 An input transfer occurs on a cycle where in_valid and in_ready are both 1; an output transfer occurs on a cycle where out_valid and out_ready are both 1.
REQ-019 When Opr=0: Sum = Mmax + Mmin, zero-extended to MANTISSA+2 bits, with no truncation; PSgn = Sa.
REQ-020 When Opr=1 and Mmax >= Mmin: Sum = Mmax - Mmin; PSgn = Sa.
REQ-021 When Opr=1 and Mmin > Mmax, the upstream swap was violated: Sum = Mmin - Mmax and PSgn = ~Sa.
REQ-022 When Opr=1 and the difference is zero: Sum = 0 and PSgn = 0, giving +0.
REQ-023 The result is computed combinationally and registered at the input transfer, so latency is 1 cycle: out_valid rises on the edge after the input transfer.
REQ-024 Storage is a main register plus one skid register; the state machine has three states: EMPTY, ONE (main full), TWO (main and skid full).
REQ-025 EMPTY: on input transfer go to ONE; otherwise stay in EMPTY.
REQ-026 ONE: on input transfer without output transfer go to TWO, with the new data into skid.
REQ-027 ONE: on output transfer without input transfer go to EMPTY.
REQ-028 ONE: on both transfers in the same cycle stay in ONE, with the new data into main.
REQ-029 ONE: on neither transfer stay in ONE.
REQ-030 TWO: on output transfer go to ONE and move skid to main; otherwise stay in TWO.
REQ-031 in_ready is a registered output: 1 when the next state is EMPTY or ONE, 0 when the next state is TWO; in_valid is ignored while in_ready = 0.
REQ-032 out_valid = 1 exactly in states ONE and TWO; Sum, PSgn and ExOut always reflect the main register.
REQ-033 Outputs hold stable while out_valid = 1 and out_ready = 0.
REQ-034 Results leave in strict acceptance order; no result is dropped or duplicated.
REQ-035 op_count increments by 1 on each input transfer and saturates at 16'hFFFF.

Reset
REQ-036 While resetn = 0 at a clock edge, the next state is EMPTY and in_ready, out_valid, Sum, PSgn, ExOut and op_count are all 0.
REQ-037 Reset asserted mid-operation discards all held results immediately; no transfer completes on that edge.
REQ-038 in_ready = 1 from the first edge at which resetn is sampled 1.

Verification
REQ-039 Add: Mmax=11'h400, Mmin=11'h200, Opr=0, Sa=1, Ex=5'h0F -> one cycle later out_valid=1, Sum=12'h600, PSgn=1, ExOut=5'h0F.
REQ-040 Carry: Mmax=Mmin=11'h7FF, Opr=0 -> Sum=12'hFFE.
REQ-041 Cancel and swap: Opr=1, Mmax=Mmin=11'h5A5, Sa=1 -> Sum=0, PSgn=0; then Mmax=11'h100, Mmin=11'h300, Sa=0 -> Sum=12'h200, PSgn=1.
REQ-042 Backpressure: out_ready=0 with 3 back-to-back valid inputs -> first two accepted, in_ready=0 from the second acceptance onward, third held; releasing out_ready yields the results in order with no loss, and op_count=3.
REQ-043 Reset mid-operation: state TWO, then resetn=0 for 1 cycle -> out_valid=0 and op_count=0; in_ready=1 one cycle after release; no stale result appears.
REQ-044 Saturation: preload 65535 acceptances, then one more input -> op_count stays 16'hFFFF.

Source files
------------

// File: rtl/fpaddsub_exec_stage.sv
// Mantissa add/subtract execute stage of a floating-point adder.
// Takes aligned mantissas from the alignment stage, produces the raw
// mantissa sum/difference with carry and the result sign, and buffers
// results in a two-entry (main + skid) elastic stage toward the normaliser.
module fpaddsub_exec_stage #(
  parameter int MANTISSA = 10,
  parameter int EXPONENT = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANTISSA:0]     Mmax,
  input  logic [MANTISSA:0]     Mmin,
  input  logic                  Opr,
  input  logic                  Sa,
  input  logic [EXPONENT-1:0]   Ex,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANTISSA+1:0]   Sum,
  output logic                  PSgn,
  output logic [EXPONENT-1:0]   ExOut,
  output logic [15:0]           op_count
);

  localparam int SW = MANTISSA + 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [15:0]           r_op_count;

  logic [SW-1:0]         r_main_sum;
  logic                  r_main_psgn;
  logic [EXPONENT-1:0]   r_main_ex;
  logic [SW-1:0]         r_skid_sum;
  logic                  r_skid_psgn;
  logic [EXPONENT-1:0]   r_skid_ex;

  logic [SW-1:0]         w_res_sum;
  logic                  w_res_psgn;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_load_main_in;
  logic                  w_load_main_skid;
  logic                  w_load_skid;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  // Mantissa arithmetic: add keeps the carry; subtract recovers from a
  // violated upstream swap by flipping the sign; exact cancellation is +0.
  always_comb begin
    w_res_sum  = {SW{1'b0}};
    w_res_psgn = 1'b0;
    if (Opr == 1'b0) begin
      w_res_sum  = {1'b0, Mmax} + {1'b0, Mmin};
      w_res_psgn = Sa;
    end else if (Mmax == Mmin) begin
      w_res_sum  = {SW{1'b0}};
      w_res_psgn = 1'b0;
    end else if (Mmax > Mmin) begin
      w_res_sum  = {1'b0, Mmax - Mmin};
      w_res_psgn = Sa;
    end else begin
      w_res_sum  = {1'b0, Mmin - Mmax};
      w_res_psgn = ~Sa;
    end
  end

  // Occupancy FSM next state and register load selects.
  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_next_state   = ST_ONE;
          w_load_main_in = 1'b1;
        end else begin
          w_next_state   = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && !w_out_xfer) begin
          w_next_state = ST_TWO;
          w_load_skid  = 1'b1;
        end else if (!w_in_xfer && w_out_xfer) begin
          w_next_state = ST_EMPTY;
        end else if (w_in_xfer && w_out_xfer) begin
          w_next_state   = ST_ONE;
          w_load_main_in = 1'b1;
        end else begin
          w_next_state = ST_ONE;
        end
      end
      ST_TWO: begin
        if (w_out_xfer) begin
          w_next_state     = ST_ONE;
          w_load_main_skid = 1'b1;
        end else begin
          w_next_state     = ST_TWO;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
  end

  // State, registered handshake outputs and saturating acceptance counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_op_count  <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != ST_TWO);
      r_out_valid <= (w_next_state != ST_EMPTY);
      if (w_in_xfer && (r_op_count != 16'hFFFF)) begin
        r_op_count <= r_op_count + 16'd1;
      end else begin
        r_op_count <= r_op_count;
      end
    end
  end

  // Main and skid result registers; main always drives the outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_main_sum  <= {SW{1'b0}};
      r_main_psgn <= 1'b0;
      r_main_ex   <= {EXPONENT{1'b0}};
      r_skid_sum  <= {SW{1'b0}};
      r_skid_psgn <= 1'b0;
      r_skid_ex   <= {EXPONENT{1'b0}};
    end else begin
      if (w_load_main_in) begin
        r_main_sum  <= w_res_sum;
        r_main_psgn <= w_res_psgn;
        r_main_ex   <= Ex;
      end else if (w_load_main_skid) begin
        r_main_sum  <= r_skid_sum;
        r_main_psgn <= r_skid_psgn;
        r_main_ex   <= r_skid_ex;
      end else begin
        r_main_sum  <= r_main_sum;
        r_main_psgn <= r_main_psgn;
        r_main_ex   <= r_main_ex;
      end
      if (w_load_skid) begin
        r_skid_sum  <= w_res_sum;
        r_skid_psgn <= w_res_psgn;
        r_skid_ex   <= Ex;
      end else begin
        r_skid_sum  <= r_skid_sum;
        r_skid_psgn <= r_skid_psgn;
        r_skid_ex   <= r_skid_ex;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Sum       = r_main_sum;
  assign PSgn      = r_main_psgn;
  assign ExOut     = r_main_ex;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_fpaddsub_exec_stage.sv
// Self-checking bench for fpaddsub_exec_stage: directed vector table,
// hand-written backpressure/reset/saturation sequences and random traffic
// against a queue-based reference model.
module tb_fpaddsub_exec_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] Mmax;
  logic [10:0] Mmin;
  logic        Opr;
  logic        Sa;
  logic [4:0]  Ex;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] Sum;
  logic        PSgn;
  logic [4:0]  ExOut;
  logic [15:0] op_count;

  fpaddsub_exec_stage #(.MANTISSA(10), .EXPONENT(5)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .Mmax(Mmax), .Mmin(Mmin), .Opr(Opr), .Sa(Sa), .Ex(Ex),
    .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .PSgn(PSgn),
    .ExOut(ExOut), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] sum;
    logic        psgn;
    logic [4:0]  ex;
  } res_t;

  typedef struct {
    logic [10:0] mmax;
    logic [10:0] mmin;
    logic        opr;
    logic        sa;
    logic [4:0]  ex;
    logic [11:0] sum;
    logic        psgn;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  res_t q[$];
  int   m_cnt    = 0;
  bit   m_rst    = 1'b1;

  // Reference: signed integer arithmetic on the mantissa values.
  function automatic res_t ref_calc(input logic [10:0] mx, input logic [10:0] mn,
                                    input logic op, input logic sa, input logic [4:0] ex);
    res_t r;
    int   a, b, d, s;
    a = int'(mx);
    b = int'(mn);
    r.ex = ex;
    if (op == 1'b0) begin
      s = a + b;
      r.psgn = sa;
    end else begin
      d = a - b;
      if (d > 0) begin
        s = d; r.psgn = sa;
      end else if (d < 0) begin
        s = -d; r.psgn = ~sa;
      end else begin
        s = 0; r.psgn = 1'b0;
      end
    end
    r.sum = s[11:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, then
  // advance the model across the rising edge.
  task automatic step(input bit v, input logic [10:0] mx, input logic [10:0] mn,
                      input bit op, input bit sa, input logic [4:0] ex,
                      input bit ordy, output bit acc);
    bit   exp_rdy, exp_vld, out_x;
    res_t r;
    in_valid = v; Mmax = mx; Mmin = mn; Opr = op; Sa = sa; Ex = ex; out_ready = ordy;
    #1;
    exp_rdy = !m_rst && (q.size() < 2);
    exp_vld = !m_rst && (q.size() > 0);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
    chk("op_count", {16'd0, op_count}, m_cnt);
    if (exp_vld) begin
      chk("Sum", {20'd0, Sum}, {20'd0, q[0].sum});
      chk("PSgn", {31'd0, PSgn}, {31'd0, q[0].psgn});
      chk("ExOut", {27'd0, ExOut}, {27'd0, q[0].ex});
    end else if (m_rst) begin
      chk("Sum_rst", {20'd0, Sum}, 32'd0);
      chk("PSgn_rst", {31'd0, PSgn}, 32'd0);
      chk("ExOut_rst", {27'd0, ExOut}, 32'd0);
    end
    acc   = resetn && v && exp_rdy;
    out_x = resetn && ordy && exp_vld;
    r = ref_calc(mx, mn, op, sa, ex);
    @(posedge clk);
    if (!resetn) begin
      q.delete();
      m_cnt = 0;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (out_x) void'(q.pop_front());
      if (acc) begin
        q.push_back(r);
        if (m_cnt < 65535) m_cnt++;
      end
    end
    @(negedge clk);
  endtask

  vec_t tv[4];

  initial begin
    bit          acc;
    bit          got_c;
    int          guard;
    logic [10:0] rx, rn;

    tv[0] = '{mmax: 11'h400, mmin: 11'h200, opr: 1'b0, sa: 1'b1, ex: 5'h0F, sum: 12'h600, psgn: 1'b1};
    tv[1] = '{mmax: 11'h7FF, mmin: 11'h7FF, opr: 1'b0, sa: 1'b0, ex: 5'h03, sum: 12'hFFE, psgn: 1'b0};
    tv[2] = '{mmax: 11'h5A5, mmin: 11'h5A5, opr: 1'b1, sa: 1'b1, ex: 5'h1E, sum: 12'h000, psgn: 1'b0};
    tv[3] = '{mmax: 11'h100, mmin: 11'h300, opr: 1'b1, sa: 1'b0, ex: 5'h11, sum: 12'h200, psgn: 1'b1};

    resetn = 1'b0; in_valid = 1'b0; Mmax = 11'd0; Mmin = 11'd0;
    Opr = 1'b0; Sa = 1'b0; Ex = 5'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_rst  = 1'b1;
    resetn = 1'b1;

    // Directed vectors, one per cycle with the sink always ready.
    step(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 5'd0, 1'b1, acc);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, tv[i].mmax, tv[i].mmin, tv[i].opr, tv[i].sa, tv[i].ex, 1'b1, acc);
      chk("vec_valid", {31'd0, out_valid}, 32'd1);
      chk("vec_sum", {20'd0, Sum}, {20'd0, tv[i].sum});
      chk("vec_psgn", {31'd0, PSgn}, {31'd0, tv[i].psgn});
      chk("vec_ex", {27'd0, ExOut}, {27'd0, tv[i].ex});
    end
    step(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 5'd0, 1'b1, acc);

    // Fill to TWO, then reset for one cycle while offering traffic.
    step(1'b1, 11'h123, 11'h045, 1'b0, 1'b0, 5'h01, 1'b0, acc);
    step(1'b1, 11'h321, 11'h054, 1'b1, 1'b1, 5'h02, 1'b0, acc);
    chk("two_in_ready", {31'd0, in_ready}, 32'd0);
    resetn = 1'b0;
    step(1'b1, 11'h222, 11'h111, 1'b0, 1'b0, 5'h03, 1'b1, acc);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    resetn = 1'b1;
    step(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 5'd0, 1'b1, acc);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_no_stale", {31'd0, out_valid}, 32'd0);

    // Backpressure: three back-to-back offers with the sink stalled.
    step(1'b1, 11'h010, 11'h001, 1'b0, 1'b0, 5'h04, 1'b0, acc);
    step(1'b1, 11'h020, 11'h002, 1'b1, 1'b1, 5'h05, 1'b0, acc);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 11'h003, 11'h030, 1'b1, 1'b0, 5'h06, 1'b0, acc);
    chk("bp_third_held", {31'd0, acc}, 32'd0);
    got_c = 1'b0;
    guard = 0;
    while ((!got_c || q.size() != 0) && guard < 20) begin
      step(!got_c, 11'h003, 11'h030, 1'b1, 1'b0, 5'h06, 1'b1, acc);
      if (acc) got_c = 1'b1;
      guard++;
    end
    chk("bp_drain_timeout", guard, (guard < 20) ? guard : 32'd0);
    chk("bp_op_count", {16'd0, op_count}, 32'd3);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rx = 11'($urandom);
      rn = 11'($urandom);
      if (($urandom_range(0, 3)) == 0) rn = rx;
      step(bit'($urandom_range(0, 1)), rx, rn, bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), 5'($urandom), ($urandom_range(0, 9) < 7), acc);
    end
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      step(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 5'd0, 1'b1, acc);
      guard++;
    end
    chk("rand_drain", q.size(), 32'd0);

    // Saturation of the acceptance counter.
    guard = 0;
    while (m_cnt < 65535 && guard < 70000) begin
      step(1'b1, 11'($urandom), 11'($urandom), bit'($urandom_range(0, 1)),
           1'b0, 5'd7, 1'b1, acc);
      guard++;
    end
    chk("sat_reached", {16'd0, op_count}, 32'hFFFF);
    step(1'b1, 11'h001, 11'h001, 1'b0, 1'b0, 5'd1, 1'b1, acc);
    step(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 5'd0, 1'b1, acc);
    chk("sat_hold", {16'd0, op_count}, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
